melody_sequencer: RTL and testbench

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

---
 rtl/melody_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_melody_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// Song-ROM driven melody sequencer: walks pitch/duration entries and hands the
// speaker datapath a half-period divider plus an amplitude for each note.
module melody_sequencer #(
    parameter int unsigned CLK_HZ   = 40000000,
    parameter int unsigned BEAT_CYC = 10000000,
    parameter int unsigned GAP_CYC  = 400000,
    parameter logic [15:0] VOLUME   = 16'h4000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        play,
    input  logic        pause,
    input  logic        stop,
    input  logic        loop_en,
    output logic [4:0]  rom_addr,
    input  logic [7:0]  rom_data,
    output logic [19:0] note_div,
    output logic [15:0] sound,
    output logic        busy,
    output logic        song_done
);
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 20;
    localparam int unsigned SW = 16;
    localparam int unsigned CW = 24;
    localparam logic [AW-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, PAUSED} state_t;

    // Divider table for C4..B4, rounded half-periods from micro-hertz frequencies.
    function automatic logic [12*DW-1:0] build_div_tab();
        logic [12*DW-1:0] tab;
        longint unsigned  f_uhz;
        tab = '0;
        for (int i = 0; i < 12; i++) begin
            case (i)
                0:       f_uhz = 64'd261625565;
                1:       f_uhz = 64'd277182631;
                2:       f_uhz = 64'd293664768;
                3:       f_uhz = 64'd311126984;
                4:       f_uhz = 64'd329627557;
                5:       f_uhz = 64'd349228231;
                6:       f_uhz = 64'd369994423;
                7:       f_uhz = 64'd391995436;
                8:       f_uhz = 64'd415304698;
                9:       f_uhz = 64'd440000000;
                10:      f_uhz = 64'd466163762;
                default: f_uhz = 64'd493883301;
            endcase
            tab[i*DW +: DW] = DW'((64'(CLK_HZ) * 64'd1000000 + f_uhz) / (64'd2 * f_uhz));
        end
        return tab;
    endfunction

    localparam logic [12*DW-1:0] DIV_TAB = build_div_tab();

    function automatic logic [DW-1:0] div_lookup(input logic [3:0] code);
        logic [3:0] idx;
        idx = code - 4'd1;
        return DIV_TAB[32'(idx) * DW +: DW];
    endfunction

    state_t        state, state_d, ret_state, ret_state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [3:0]    dur, dur_d;
    logic          rest, rest_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] div_d;
    logic [SW-1:0] sound_d;
    logic          done_d;
    logic          finish_note, song_end;

    logic [3:0]    ld_pitch, ld_dur;
    logic          ld_rest;
    logic [CW-1:0] play_len, on_len;

    assign ld_pitch = rom_data[7:4];
    assign ld_dur   = rom_data[3:0];
    assign ld_rest  = (ld_pitch == 4'd0) || (ld_pitch > 4'd12);
    assign play_len = CW'(dur) * CW'(BEAT_CYC);
    assign on_len   = play_len - CW'(GAP_CYC);

    // Next-state and next-output logic; cnt holds the index of the PLAY cycle in progress.
    always_comb begin
        state_d     = state;
        ret_state_d = ret_state;
        cnt_d       = cnt;
        dur_d       = dur;
        rest_d      = rest;
        addr_d      = rom_addr;
        div_d       = note_div;
        sound_d     = '0;
        done_d      = 1'b0;
        finish_note = 1'b0;
        song_end    = 1'b0;

        if (stop) begin
            state_d = IDLE;
            addr_d  = '0;
            cnt_d   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (play) begin
                        state_d = FETCH;
                        addr_d  = '0;
                    end
                end
                FETCH: begin
                    if (pause) begin
                        state_d     = PAUSED;
                        ret_state_d = FETCH;
                    end else begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    if (pause) begin
                        state_d     = PAUSED;
                        ret_state_d = LOAD;
                    end else if (ld_dur == 4'd0) begin
                        song_end = 1'b1;
                    end else begin
                        dur_d   = ld_dur;
                        rest_d  = ld_rest;
                        cnt_d   = '0;
                        state_d = PLAY;
                        if (!ld_rest) begin
                            div_d   = div_lookup(ld_pitch);
                            sound_d = VOLUME;
                        end
                    end
                end
                PLAY: begin
                    if (pause) begin
                        // The current cycle still counts toward the note length.
                        state_d     = PAUSED;
                        ret_state_d = PLAY;
                        cnt_d       = cnt + CW'(1);
                    end else if (cnt == play_len - CW'(1)) begin
                        finish_note = 1'b1;
                    end else begin
                        cnt_d = cnt + CW'(1);
                        if (!rest && (cnt_d < on_len)) sound_d = VOLUME;
                    end
                end
                PAUSED: begin
                    if (play) begin
                        if ((ret_state == PLAY) && (cnt == play_len)) begin
                            finish_note = 1'b1;
                        end else begin
                            state_d = ret_state;
                            if ((ret_state == PLAY) && !rest && (cnt < on_len)) sound_d = VOLUME;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            if (finish_note) begin
                if (rom_addr == LAST_ADDR) begin
                    song_end = 1'b1;
                end else begin
                    addr_d  = rom_addr + AW'(1);
                    state_d = FETCH;
                end
            end

            if (song_end) begin
                addr_d = '0;
                if (loop_en) begin
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ret_state <= IDLE;
            cnt       <= '0;
            dur       <= '0;
            rest      <= 1'b1;
            rom_addr  <= '0;
            note_div  <= '0;
            sound     <= '0;
            busy      <= 1'b0;
            song_done <= 1'b0;
        end else begin
            state     <= state_d;
            ret_state <= ret_state_d;
            cnt       <= cnt_d;
            dur       <= dur_d;
            rest      <= rest_d;
            rom_addr  <= addr_d;
            note_div  <= div_d;
            sound     <= sound_d;
            busy      <= (state_d != IDLE);
            song_done <= done_d;
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: directed songs plus randomized transport pulses,
// checked cycle by cycle against a song-position reference model.
module tb_melody_sequencer;
    localparam int unsigned BEAT = 8;
    localparam int unsigned GAP  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        play, pause, stop, loop_en;
    logic [4:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [19:0] note_div;
    logic [15:0] sound;
    logic        busy, song_done;

    logic [7:0]  rom [32];
    int          exp_div [16];

    int n_checks = 0;
    int n_fail   = 0;
    int n_snd, n_done;

    // Reference model: position inside the current entry (0 fetch, 1 load, 2.. note cycles)
    bit m_active, m_paused, m_aud, m_done;
    int m_addr, m_pos, m_len, m_div;

    melody_sequencer #(
        .CLK_HZ  (40000000),
        .BEAT_CYC(BEAT),
        .GAP_CYC (GAP),
        .VOLUME  (16'h4000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .play     (play),
        .pause    (pause),
        .stop     (stop),
        .loop_en  (loop_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .note_div (note_div),
        .sound    (sound),
        .busy     (busy),
        .song_done(song_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_paused = 0; m_aud = 0; m_done = 0;
        m_addr = 0; m_pos = 0; m_len = 0; m_div = 0;
    endtask

    task automatic end_song(input bit lp);
        m_addr = 0;
        m_pos  = 0;
        if (!lp) begin
            m_active = 0;
            m_done   = 1;
        end
    endtask

    task automatic next_entry(input bit lp);
        if (m_addr == 31) end_song(lp);
        else begin
            m_addr++;
            m_pos = 0;
        end
    endtask

    task automatic model_step(input bit p, input bit ps, input bit st, input bit lp);
        int d, code;
        m_done = 0;
        if (st) begin
            m_active = 0; m_paused = 0; m_addr = 0; m_pos = 0;
        end else if (!m_active) begin
            if (p) begin
                m_active = 1; m_paused = 0; m_addr = 0; m_pos = 0;
            end
        end else if (m_paused) begin
            if (p) begin
                m_paused = 0;
                if (m_pos == m_len + 2) next_entry(lp);
            end
        end else if (ps) begin
            m_paused = 1;
            if (m_pos >= 2) m_pos++;
        end else if (m_pos == 0) begin
            m_pos = 1;
        end else if (m_pos == 1) begin
            d    = int'(rom[m_addr][3:0]);
            code = int'(rom[m_addr][7:4]);
            if (d == 0) end_song(lp);
            else begin
                m_len = d * int'(BEAT);
                m_aud = (code >= 1 && code <= 12);
                if (m_aud) m_div = exp_div[code];
                m_pos = 2;
            end
        end else begin
            m_pos++;
            if (m_pos == m_len + 2) next_entry(lp);
        end
    endtask

    task automatic compare();
        logic [15:0] es;
        es = (m_active && !m_paused && m_pos >= 2 && m_aud && (m_pos - 2) < m_len - int'(GAP))
             ? 16'h4000 : 16'h0000;
        check("rom_addr", 32'(rom_addr), 32'(m_addr));
        check("note_div", 32'(note_div), 32'(m_div));
        check("sound", 32'(sound), 32'(es));
        check("busy", 32'(busy), 32'(m_active));
        check("song_done", 32'(song_done), 32'(m_done));
        if (sound != 16'h0) n_snd++;
        if (song_done) n_done++;
    endtask

    // One clock: drive pulses from a falling edge, step the model at the rising edge.
    task automatic cyc(input logic p, input logic ps, input logic st);
        play = p; pause = ps; stop = st;
        @(posedge clk);
        model_step(p, ps, st, loop_en);
        @(negedge clk);
        play = 0; pause = 0; stop = 0;
        compare();
    endtask

    task automatic idle_cyc(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        play = 0; pause = 0; stop = 0;
        #1;
        model_reset();
        compare();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int k;
        k = 0;
        while (busy && k < budget) begin
            cyc(1'b0, 1'b0, 1'b0);
            k++;
        end
        check({tag, "_idle_timeout"}, 32'(busy), 32'(0));
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    endtask

    initial begin
        real f;
        rst_n = 1'b0;
        play = 0; pause = 0; stop = 0; loop_en = 0;
        clear_rom();
        for (int c = 0; c < 16; c++) begin
            f = 440.0 * (2.0 ** ((real'(c) - 10.0) / 12.0));
            exp_div[c] = int'($floor(40000000.0 / (2.0 * f) + 0.5));
        end
        model_reset();
        @(negedge clk);
        do_reset();
        check("reset_note_div", 32'(note_div), 32'(0));

        // A4 for two beats then end marker
        clear_rom(); rom[0] = 8'hA2;
        n_snd = 0; n_done = 0;
        cyc(1'b1, 1'b0, 1'b0);
        run_until_idle(100, "a4");
        check("a4_div", 32'(note_div), 32'(45455));
        check("a4_sound_cycles", 32'(n_snd), 32'(14));
        check("a4_done_pulses", 32'(n_done), 32'(1));
        check("a4_addr_end", 32'(rom_addr), 32'(0));

        // rest beat, then C4 beat
        clear_rom(); rom[0] = 8'h01; rom[1] = 8'h11;
        n_snd = 0; n_done = 0;
        cyc(1'b1, 1'b0, 1'b0);
        idle_cyc(10);
        check("rest_second_fetch_addr", 32'(rom_addr), 32'(1));
        run_until_idle(100, "c4");
        check("c4_div", 32'(note_div), 32'(76445));
        check("c4_sound_cycles", 32'(n_snd), 32'(6));

        // pause mid-note, hold, resume: audible time unchanged
        clear_rom(); rom[0] = 8'h53;
        n_snd = 0; n_done = 0;
        cyc(1'b1, 1'b0, 1'b0);
        idle_cyc(4);
        cyc(1'b0, 1'b1, 1'b0);
        idle_cyc(20);
        check("pause_sound_silent", 32'(sound), 32'(0));
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        run_until_idle(100, "pause");
        check("pause_sound_cycles", 32'(n_snd), 32'(22));
        check("pause_done_pulses", 32'(n_done), 32'(1));

        // looping two-entry song never finishes
        clear_rom(); rom[0] = 8'h11;
        loop_en = 1'b1;
        n_snd = 0; n_done = 0;
        cyc(1'b1, 1'b0, 1'b0);
        idle_cyc(60);
        check("loop_no_done", 32'(n_done), 32'(0));
        cyc(1'b0, 1'b0, 1'b1);
        loop_en = 1'b0;

        // stop with play in the same cycle during a note
        clear_rom(); rom[0] = 8'hA3;
        n_done = 0;
        cyc(1'b1, 1'b0, 1'b0);
        idle_cyc(6);
        cyc(1'b1, 1'b0, 1'b1);
        check("stop_busy", 32'(busy), 32'(0));
        check("stop_addr", 32'(rom_addr), 32'(0));
        check("stop_sound", 32'(sound), 32'(0));
        idle_cyc(3);
        check("stop_no_done", 32'(n_done), 32'(0));

        // reset mid-song
        cyc(1'b1, 1'b0, 1'b0);
        idle_cyc(5);
        do_reset();
        idle_cyc(2);
        check("midreset_no_done", 32'(n_done), 32'(0));

        // full 32-entry song
        for (int i = 0; i < 32; i++) rom[i] = {4'($urandom_range(0, 15)), 4'd1};
        n_done = 0;
        cyc(1'b1, 1'b0, 1'b0);
        run_until_idle(500, "full");
        check("full_done_pulses", 32'(n_done), 32'(1));
        check("full_addr_end", 32'(rom_addr), 32'(0));

        // randomized transport pulses over random songs
        for (int t = 0; t < 3000; t++) begin
            logic p, ps, st;
            if (t % 700 == 699) begin
                do_reset();
            end else if (t % 300 == 0) begin
                if (busy) cyc(1'b0, 1'b0, 1'b1);
                for (int i = 0; i < 32; i++) begin
                    rom[i][7:4] = 4'($urandom_range(0, 15));
                    rom[i][3:0] = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
                end
                loop_en = 1'($urandom_range(0, 1));
            end else begin
                p  = busy ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 4) == 0);
                ps = ($urandom_range(0, 29) == 0);
                st = ($urandom_range(0, 199) == 0);
                cyc(p, ps, st);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
